// File: rtl/hash_mem_arbiter.sv
// Purpose: round-robin, burst-locked sharing of one memory port among NUM_REQ hash engines.
// Latency: req->gnt 1 cycle, gnt->access 0 cycles, read->rvalid 1 cycle, release->next gnt 1 cycle (2 with HASH_ARB_TURNAROUND_EN).
// Backpressure: waiting engines hold req until their gnt; the owner keeps the port until it drops req.
// Optional macro HASH_ARB_TURNAROUND_EN: every release passes through a one-cycle idle GAP state.
module hash_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           rvalid,
  output logic [DATA_W-1:0]            rdata,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   owner,
  output logic                         mem_clk,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_write_data,
  input  logic [DATA_W-1:0]            mem_read_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN
`ifdef HASH_ARB_TURNAROUND_EN
    , ST_GAP
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;

  // First requester strictly after 'last', wrapping; 'last' itself is checked last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && r[idx[IDX_W-1:0]]) begin
        pick  = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Ownership FSM: grant on request, hold while the owner's req stays high, hand off on release.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d = rr_pick(req, last_owner_q);
          gnt_d   = onehot(owner_d);
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!req[owner_q]) begin
          last_owner_d = owner_q;
`ifdef HASH_ARB_TURNAROUND_EN
          gnt_d   = '0;
          state_d = ST_GAP;
`else
          // Back-to-back handoff; the releasing engine has req low so it cannot win here.
          if (|req) begin
            owner_d = rr_pick(req, owner_q);
            gnt_d   = onehot(owner_d);
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
`endif
        end
      end
`ifdef HASH_ARB_TURNAROUND_EN
      ST_GAP: begin
        if (|req) begin
          owner_d = rr_pick(req, last_owner_q);
          gnt_d   = onehot(owner_d);
          state_d = ST_OWN;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read tag follows the engine index, so it survives a handoff on the next edge.
  always_comb begin
    rvalid_d = gnt_q & req & ~req_we;
  end

  // Port mux: only the granted engine with req high drives the memory; otherwise all zeros.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i] && req[i]) begin
        mem_we         = req_we[i];
        mem_addr       = req_addr[i*ADDR_W +: ADDR_W];
        mem_write_data = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // State registers; last_owner resets to the top index so engine 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      rvalid_q     <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign gnt     = gnt_q;
  assign rvalid  = rvalid_q;
  assign busy    = |gnt_q;
  assign owner   = owner_q;
  assign rdata   = mem_read_data;
  assign mem_clk = clk;

endmodule

// File: tb/tb_hash_mem_arbiter.sv
// Bench for hash_mem_arbiter (NUM_REQ=4): directed scenarios, then random traffic against a behavioural model.
// Memory model below has one-cycle read latency; unwritten words read as {16'hBEEF, addr}.
// Handoff latency expectations follow HASH_ARB_TURNAROUND_EN when it is defined for the build.
module tb_hash_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
`ifdef HASH_ARB_TURNAROUND_EN
  localparam int TA = 1;
`else
  localparam int TA = 0;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [1:0]      owner;
  logic            mem_clk, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_write_data, mem_read_data;

  int n_assert = 0;
  int n_fail   = 0;

  hash_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .owner(owner), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory behind the port
  logic [31:0]   mem [0:1023];
  logic [1023:0] mem_ok = '0;
  always @(posedge mem_clk) begin
    if (mem_we) begin
      mem[mem_addr[9:0]]    <= mem_write_data;
      mem_ok[mem_addr[9:0]] <= 1'b1;
    end
    mem_read_data <= mem_ok[mem_addr[9:0]] ? mem[mem_addr[9:0]] : {16'hBEEF, mem_addr};
  end

  // Reference contents, updated only from the bench's own stimulus
  logic [31:0]   mdl [0:1023];
  logic [1023:0] mdl_ok = '0;

  task automatic mdl_wr(input logic [15:0] a, input logic [31:0] d);
    mdl[a[9:0]]    = d;
    mdl_ok[a[9:0]] = 1'b1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [15:0] a);
    return mdl_ok[a[9:0]] ? mdl[a[9:0]] : {16'hBEEF, a};
  endfunction

  // Round robin as "smallest forward distance from the last owner"
  function automatic int rr_model(input logic [N-1:0] r, input int last);
    int best   = -1;
    int best_d = 99;
    int d;
    for (int j = 0; j < N; j++) begin
      d = (j - last - 1 + 2*N) % N;
      if (r[j] && d < best_d) begin
        best_d = d;
        best   = j;
      end
    end
    return best;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic we, input logic [15:0] a, input logic [31:0] d);
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  // Ticks until some grant appears (bounded); returns cycles counted including the first tick.
  task automatic wait_gnt(output int cnt);
    tick();
    cnt = 1;
    while (gnt == '0 && cnt < 10) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          cnt;
  int          m_own, m_last, m_ownout;
  bit          m_gap, acc;
  logic [N-1:0] exp_rv, exp_g;
  logic [31:0] exp_rdat;
  logic [15:0] e_addr;
  logic [31:0] e_wd;
  logic        e_we;
  int          blen [N];

  initial begin
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    // Reset values
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_owner", 64'(owner), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_write_data), 64'(0));
    reset_n = 1'b1;

    // All four request at cycle 0; engine 0 first, then rotate by releasing
    req = 4'b1111;
    tick();
    chk("t1_first_gnt", 64'(gnt), 64'(4'b0001));
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_owner", 64'(owner), 64'(0));
    for (int k = 1; k <= 4; k++) begin
      req[(k-1)%N] = 1'b0;
      tick();
      req[(k-1)%N] = 1'b1;
      cnt = 1;
      while (gnt == '0 && cnt < 10) begin
        tick();
        cnt++;
      end
      chk("t1_handoff_lat", 64'(cnt), 64'(1 + TA));
      chk("t1_order_gnt", 64'(gnt), 64'(1) << (k % N));
      chk("t1_order_owner", 64'(owner), 64'(k % N));
    end
    req = '0;
    tick(); tick();
    chk("t1_idle_busy", 64'(busy), 64'(0));
    chk("t1_idle_owner", 64'(owner), 64'(0));

    // Engine 2 reads 20 words 0x10..0x23
    req = 4'b0100;
    tick();
    chk("t2_gnt", 64'(gnt), 64'(4'b0100));
    for (int k = 0; k < 20; k++) begin
      drive(2, 1'b0, 16'(16'h0010 + k), 32'h0);
      #1;
      chk("t2_addr", 64'(mem_addr), 64'(16'h0010 + k));
      chk("t2_we", 64'(mem_we), 64'(0));
      chk("t2_rvalid", 64'(rvalid), (k == 0) ? 64'(0) : 64'(4'b0100));
      if (k > 0) chk("t2_rdata", 64'(rdata), 64'(exp_rd(16'(16'h000F + k))));
      tick();
    end
    req = '0;
    drive(2, 1'b0, 16'h0, 32'h0);
    #1;
    chk("t2_last_rvalid", 64'(rvalid), 64'(4'b0100));
    chk("t2_last_rdata", 64'(rdata), 64'(exp_rd(16'h0023)));
    chk("t2_rel_addr", 64'(mem_addr), 64'(0));
    tick();
    chk("t2_rvalid_off", 64'(rvalid), 64'(0));
    chk("t2_gnt_off", 64'(gnt), 64'(0));

    // Engine 1 writes 16 words 0x100..0x10F with 0xA0000000+n
    req = 4'b0010;
    tick();
    chk("t3_gnt", 64'(gnt), 64'(4'b0010));
    for (int n = 0; n < 16; n++) begin
      drive(1, 1'b1, 16'(16'h0100 + n), 32'(32'hA000_0000 + n));
      mdl_wr(16'(16'h0100 + n), 32'(32'hA000_0000 + n));
      #1;
      chk("t3_we", 64'(mem_we), 64'(1));
      chk("t3_addr", 64'(mem_addr), 64'(16'h0100 + n));
      chk("t3_wdata", 64'(mem_write_data), 64'(32'hA000_0000 + n));
      chk("t3_rvalid", 64'(rvalid), 64'(0));
      tick();
    end
    req = '0;
    drive(1, 1'b0, 16'h0, 32'h0);
    #1;
    chk("t3_rel_we", 64'(mem_we), 64'(0));
    tick(); tick();
    for (int n = 0; n < 16; n++) begin
      chk("t3_mem", 64'(mem[10'(16'h0100 + n)]), 64'(32'hA000_0000 + n));
    end

    // Engine 0 reads while engine 3 waits with garbage on its slice, then hands off
    req = 4'b0001;
    tick();
    chk("t4_gnt0", 64'(gnt), 64'(4'b0001));
    req[3] = 1'b1;
    drive(3, 1'b1, 16'h03FF, 32'hDEAD_BEEF);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b0, 16'(16'h0100 + k), 32'h0);
      #1;
      chk("t4_nonowner_we", 64'(mem_we), 64'(0));
      chk("t4_addr", 64'(mem_addr), 64'(16'h0100 + k));
      tick();
    end
    req[0] = 1'b0;
    #1;
    chk("t4_rel_rvalid", 64'(rvalid), 64'(4'b0001));
    chk("t4_rel_rdata", 64'(rdata), 64'(exp_rd(16'h0103)));
    chk("t4_rel_gnt", 64'(gnt), 64'(4'b0001));
    chk("t4_rel_we", 64'(mem_we), 64'(0));
    chk("t4_rel_addr", 64'(mem_addr), 64'(0));
    wait_gnt(cnt);
    chk("t4_handoff_lat", 64'(cnt), 64'(1 + TA));
    chk("t4_gnt3", 64'(gnt), 64'(4'b1000));
    chk("t4_rvalid_after", 64'(rvalid), 64'(0));
    #1;
    chk("t4_w3_we", 64'(mem_we), 64'(1));
    chk("t4_w3_addr", 64'(mem_addr), 64'(16'h03FF));
    chk("t4_w3_wdata", 64'(mem_write_data), 64'(32'hDEAD_BEEF));
    mdl_wr(16'h03FF, 32'hDEAD_BEEF);
    tick();
    req = '0;
    drive(3, 1'b0, 16'h0, 32'h0);
    tick(); tick();

    // Reset pulse in the middle of an engine-1 burst
    req = 4'b0010;
    tick();
    chk("t5_gnt", 64'(gnt), 64'(4'b0010));
    drive(1, 1'b0, 16'h0100, 32'h0);
    tick();
    drive(1, 1'b1, 16'h0020, 32'h1234_5678);
    #1;
    chk("t5_pre_rvalid", 64'(rvalid), 64'(4'b0010));
    chk("t5_pre_we", 64'(mem_we), 64'(1));
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_async_gnt", 64'(gnt), 64'(0));
    chk("t5_async_rvalid", 64'(rvalid), 64'(0));
    chk("t5_async_we", 64'(mem_we), 64'(0));
    chk("t5_async_busy", 64'(busy), 64'(0));
    tick();
    chk("t5_hold_rvalid", 64'(rvalid), 64'(0));
    chk("t5_hold_owner", 64'(owner), 64'(0));
    reset_n = 1'b1;
    drive(1, 1'b0, 16'h0, 32'h0);
    tick();
    chk("t5_regrant", 64'(gnt), 64'(4'b0010));
    chk("t5_regrant_owner", 64'(owner), 64'(1));
    drive(1, 1'b0, 16'h0020, 32'h0);
    tick();
    chk("t5_no_write_rvalid", 64'(rvalid), 64'(4'b0010));
    chk("t5_no_write_rdata", 64'(rdata), 64'(exp_rd(16'h0020)));
    req = '0;
    drive(1, 1'b0, 16'h0, 32'h0);
    tick(); tick();

    // Engine 0 releases and re-requests at once; waiting engine 1 goes first
    req = 4'b0001;
    tick();
    chk("t6_gnt0", 64'(gnt), 64'(4'b0001));
    req = 4'b0011;
    tick();
    chk("t6_hold0", 64'(gnt), 64'(4'b0001));
    req[0] = 1'b0;
    tick();
    req[0] = 1'b1;
    cnt = 1;
    while (gnt == '0 && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("t6_lat1", 64'(cnt), 64'(1 + TA));
    chk("t6_gnt1", 64'(gnt), 64'(4'b0010));
    req[1] = 1'b0;
    wait_gnt(cnt);
    chk("t6_lat0", 64'(cnt), 64'(1 + TA));
    chk("t6_gnt0_again", 64'(gnt), 64'(4'b0001));
    req = '0;
    tick(); tick();

    // Random traffic against the behavioural model, starting from a fresh reset
    reset_n = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    tick();
    reset_n = 1'b1;
    m_own = -1; m_last = N - 1; m_ownout = 0; m_gap = 1'b0;
    exp_rv = '0; exp_rdat = '0;
    for (int i = 0; i < N; i++) blen[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_g = (m_own >= 0) ? N'(1 << m_own) : '0;
      chk("r_gnt", 64'(gnt), 64'(exp_g));
      chk("r_owner", 64'(owner), 64'(m_ownout));
      chk("r_busy", 64'(busy), 64'(m_own >= 0));
      chk("r_rvalid", 64'(rvalid), 64'(exp_rv));
      if (exp_rv != '0) chk("r_rdata", 64'(rdata), 64'(exp_rdat));
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(2) == 0) begin
            req[i]  = 1'b1;
            blen[i] = int'($urandom_range(1, 5));
          end
          drive(i, 1'($urandom), 16'($urandom), $urandom);
        end else if (gnt[i]) begin
          if (blen[i] == 0) begin
            req[i] = 1'b0;
            drive(i, 1'($urandom), 16'($urandom), $urandom);
          end else begin
            drive(i, 1'($urandom), 16'(16'h0200 + $urandom_range(31)), $urandom);
            blen[i]--;
          end
        end else begin
          drive(i, 1'($urandom), 16'($urandom), $urandom);
        end
      end
      #1;
      acc    = (m_own >= 0) && req[m_own[1:0]];
      e_we   = acc && req_we[m_own[1:0]];
      e_addr = acc ? req_addr[m_own*AW +: AW] : 16'h0;
      e_wd   = acc ? req_wdata[m_own*DW +: DW] : 32'h0;
      chk("r_mem_we", 64'(mem_we), 64'(e_we));
      chk("r_mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("r_mem_wdata", 64'(mem_write_data), 64'(e_wd));
      exp_rv   = (acc && !e_we) ? N'(1 << m_own) : '0;
      exp_rdat = exp_rd(e_addr);
      if (e_we) mdl_wr(e_addr, e_wd);
      if (m_gap) begin
        m_gap = 1'b0;
        m_own = rr_model(req, m_last);
      end else if (m_own < 0) begin
        m_own = rr_model(req, m_last);
      end else if (!req[m_own[1:0]]) begin
        m_last = m_own;
        if (TA != 0) begin
          m_own = -1;
          m_gap = 1'b1;
        end else begin
          m_own = rr_model(req, m_last);
        end
      end
      if (m_own >= 0) m_ownout = m_own;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hash_mem_arbiter.md
# hash_mem_arbiter

- Round-robin arbiter that shares the single testbench memory port (`mem_clk`/`mem_we`/`mem_addr`/`mem_write_data`/`mem_read_data`) between `NUM_REQ` hash engines.
- Examples of engines: several bitcoin/SHA-256 cores, each reading a 20-word message and writing 16 `h0` outputs.
- Grants are burst-locked: an engine keeps the port until it drops its request.
- Read data is steered back with a one-cycle-delayed valid tag.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting engines (2..8).
- `ADDR_W`, 16: memory address width.
- `DATA_W`, 32: memory data width.

Ports:
- `clk`, in, 1: single clock. Also forwarded as `mem_clk`.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req`, in, `NUM_REQ`: per-engine request. Held high for the whole burst.
- `req_we`, in, `NUM_REQ`: per-engine write enable.
- `req_addr`, in, `NUM_REQ*ADDR_W`: per-engine address. Engine i occupies slice `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`, in, `NUM_REQ*DATA_W`: per-engine write data, packed the same way as `req_addr`.
- `gnt`, out, `NUM_REQ`: one-hot ownership (registered).
- `rvalid`, out, `NUM_REQ`: read data valid for engine i.
- `rdata`, out, `DATA_W`: `mem_read_data` passed through to all engines.
- `busy`, out, 1: some engine owns the port.
- `owner`, out, `$clog2(NUM_REQ)`: index of the current or last owner.
- `mem_clk`, out, 1: equal to `clk`.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, `ADDR_W`: memory address.
- `mem_write_data`, out, `DATA_W`: memory write data.
- `mem_read_data`, in, `DATA_W`: memory read data, one-cycle latency.

## Operation
States:
- IDLE: no owner.
- OWN: `gnt[owner]` high.
- GAP: only exists with the Configuration macro.

IDLE behaviour:
- If any `req` is high, select the first requester at or after `(last_owner+1) mod NUM_REQ`.
- Register that requester as owner, assert its `gnt` at the next edge, go to OWN.

OWN behaviour:
- An access happens in every cycle where `gnt[i] && req[i]`.
- During an access, mem outputs are driven combinationally from slice i.
- In every other cycle: `mem_we=0`, `mem_addr=0`, `mem_write_data=0`.

Release:
- The owner drops `req` in cycle t. Cycle t performs no access.
- At edge t+1 its `gnt` falls and `last_owner` is updated to it.
- If other requests are pending in cycle t, the next owner is chosen by round-robin from `owner+1` and granted at edge t+1 (zero dead cycles). Otherwise go to IDLE.
- The releasing engine is re-eligible only after every other pending requester (round-robin wrap).

Read return:
- `rvalid[i]` is a registered copy of `gnt[i] & req[i] & ~req_we[i]`.
- It is high in the cycle when `mem_read_data` holds that read's word. This remains true across handoff, because the tag is registered with the index, not with current ownership.

Other rules:
- `req_we`, `req_addr` and `req_wdata` from non-owners are ignored.
- An engine must not issue an access until its `gnt` is observed high.
- `busy = |gnt`.

## Timing
Reset values:
- `gnt=0`, `rvalid=0`, `busy=0`, `owner=0`, `last_owner=NUM_REQ-1` (so engine 0 wins first).
- `mem_we=0`, `mem_addr=0`, `mem_write_data=0`.

Latency:
- Request to grant: 1 cycle.
- Grant to first access: 0 cycles, in the same cycle that `gnt` is seen.
- Read address to `rvalid`: 1 cycle.
- Release to next grant: 1 cycle (2 cycles with the macro).

Edge cases:
- Reset mid-burst: all grants and `rvalid` clear immediately (asynchronous). An in-flight read produces no `rvalid`.
- A single requester held continuously stays granted indefinitely. There is no timeout.
- Owner `req` toggling low for 1 cycle: the grant is lost. The engine re-arbitrates.

## Configuration
- `HASH_ARB_TURNAROUND_EN` defined: every release passes through GAP for exactly 1 cycle. GAP has all `gnt=0` and mem outputs at 0. Round-robin selection is made in GAP from the `req` values seen in that cycle.
- Undefined: GAP does not exist, and handoff is back-to-back.

## Test plan
All scenarios use `NUM_REQ=4`.
- Reset, then `req=4'b1111` at cycle 0: `gnt=4'b0001` at cycle 1. Releasing in sequence gives grant order 0,1,2,3,0.
- Engine 2 alone reads addresses 0x0010..0x0023 (20 words): `rvalid[2]` is high for 20 consecutive cycles, each 1 cycle after its address. `mem_we` stays 0.
- Engine 1 writes 16 words to 0x0100..0x010F with data 0xA0000000+n: memory contents match. `rvalid` stays 0.
- Engine 0 issues its last read at cycle t and drops `req` at t+1 while engine 3 is requesting: `rvalid[0]` is high at t+1, and `gnt[3]` rises at t+2 (t+3 with `HASH_ARB_TURNAROUND_EN`).
- `reset_n` is pulsed low mid-burst of engine 1: `gnt`, `rvalid` and `mem_we` go to 0 asynchronously. After release, `req=4'b0010` is granted to engine 1 one cycle later.
- Engine 0 releases and immediately re-requests while engine 1 is waiting: engine 1 is granted first, then engine 0.
